// File: rtl/delay_probe_pkg.sv
// Shared types and constants for the delay-path latency probe.
package delay_probe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      SEND  = 2'd2,
      WAIT  = 2'd3
   } probe_state_t;

   localparam logic [15:0] DEFAULT_PATTERN = 16'hA5C3;

endpackage

// File: rtl/delay_probe.sv
// Measures a delay path's latency: flushes zeros, sends one signature word,
// and counts cycles until the signature comes back (usable directly as a sel value).
module delay_probe
   import delay_probe_pkg::*;
#(
   parameter int unsigned         WIDTH   = 16,
   parameter int unsigned         LENGTH  = 1024,
   parameter logic [WIDTH-1:0]    PATTERN = WIDTH'(DEFAULT_PATTERN),
   localparam int unsigned        CNT_W   = $clog2(LENGTH + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   output logic [WIDTH-1:0] probe_out,
   input  logic [WIDTH-1:0] probe_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] delay,
   output logic             timeout,
   output logic             corrupt
);

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);

   if (PATTERN == '0 || WIDTH < 2) begin : g_param_check
      $error("delay_probe: PATTERN must be nonzero and WIDTH must be >= 2");
   end

   probe_state_t     state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [WIDTH-1:0] probe_out_next;
   logic             busy_next, done_next, timeout_next, corrupt_next;
   logic [CNT_W-1:0] delay_next;

   // State, counter and all outputs are registered together
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         cnt       <= '0;
         probe_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         delay     <= '0;
         timeout   <= 1'b0;
         corrupt   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         probe_out <= probe_out_next;
         busy      <= busy_next;
         done      <= done_next;
         delay     <= delay_next;
         timeout   <= timeout_next;
         corrupt   <= corrupt_next;
      end
   end

   // Signature is registered out of SEND, so it appears on the path during the
   // first WAIT cycle (k = 0), letting a zero-delay loop match immediately.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      probe_out_next = '0;
      busy_next      = busy;
      done_next      = 1'b0;
      delay_next     = delay;
      timeout_next   = timeout;
      corrupt_next   = corrupt;

      case (state)
         IDLE: begin
            if (start) begin
               state_next   = FLUSH;
               cnt_next     = '0;
               busy_next    = 1'b1;
               delay_next   = '0;
               timeout_next = 1'b0;
               corrupt_next = 1'b0;
            end
         end
         FLUSH: begin
            if (cnt == LEN_C) begin
               state_next = SEND;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         SEND: begin
            probe_out_next = PATTERN;
            state_next     = WAIT;
            cnt_next       = '0;
         end
         WAIT: begin
            // A match on the last cycle takes priority over timeout
            if (probe_in == PATTERN) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               delay_next = cnt;
            end else if (probe_in != '0) begin
               state_next   = IDLE;
               busy_next    = 1'b0;
               done_next    = 1'b1;
               delay_next   = cnt;
               corrupt_next = 1'b1;
            end else if (cnt == LEN_C) begin
               state_next   = IDLE;
               busy_next    = 1'b0;
               done_next    = 1'b1;
               delay_next   = LEN_C;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

endmodule
